// File: rtl/jtag_dr_bridge_pkg.sv
// jtag_dr_bridge_pkg: shared constants, synchroniser bit layout and channel-index width helper
package jtag_dr_bridge_pkg;
  localparam int JTAG_SYNC_DEFAULT = 2;
  localparam int B_TDI = 0;
  localparam int B_SHIFT = 1;
  localparam int B_UPD = 2;
  localparam int B_RSTN = 3;
  localparam int B_CE = 4;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jtag_dr_bridge_if.sv
// jtag_dr_bridge_if: SoC-side capture and write-back signals of the JTAG DR bridge
interface jtag_dr_bridge_if
  import jtag_dr_bridge_pkg::*;
#(
  parameter int DR_WIDTH = 32,
  parameter int NUM_CH = 2
);
  localparam int SW = sel_w(NUM_CH);
  logic [NUM_CH*DR_WIDTH-1:0] rd_data;
  logic cap_pulse;
  logic [SW-1:0] cap_sel;
  logic [DR_WIDTH-1:0] wr_data;
  logic [SW-1:0] wr_sel;
  logic wr_valid;
  logic wr_ready;
  logic wr_ovf;
  logic ovf_clr;
  modport master (
    input rd_data, wr_ready, ovf_clr,
    output cap_pulse, cap_sel, wr_data, wr_sel, wr_valid, wr_ovf
  );
  modport slave (
    output rd_data, wr_ready, ovf_clr,
    input cap_pulse, cap_sel, wr_data, wr_sel, wr_valid, wr_ovf
  );
endinterface

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: synchroniser bank for JTAGG levels plus TCK rising-edge detect
module jtag_sync_edge
  import jtag_dr_bridge_pkg::*;
#(
  parameter int W = 5,
  parameter int STAGES = JTAG_SYNC_DEFAULT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tck,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);
  logic [STAGES-1:0][W:0] sync_q, sync_d;
  logic tck_q, tck_d;
  // TCK travels in bit 0 so every level reaches the output on the same clk as its edge
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], {d, tck}};
    tck_d = sync_q[STAGES-1][0];
  end
  // synchroniser chain and one-bit TCK history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      tck_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tck_q <= tck_d;
    end
  end
  assign q = sync_q[STAGES-1][W:1];
  assign rise = sync_q[STAGES-1][0] & ~tck_q;
endmodule

// File: rtl/jtag_dr_bridge.sv
// jtag_dr_bridge: oversampled JTAGG user-DR bridge with capture, shift and handshaked write-back
module jtag_dr_bridge
  import jtag_dr_bridge_pkg::*;
#(
  parameter int DR_WIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int SYNC_STAGES = JTAG_SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              jtck,
  input  logic              jtdi,
  input  logic              jshift,
  input  logic              jupdate,
  input  logic              jrstn,
  input  logic [NUM_CH-1:0] jce,
  output logic [NUM_CH-1:0] jtdo,
  jtag_dr_bridge_if.master  bus
);
  localparam int SW = sel_w(NUM_CH);
  localparam int W = B_CE + NUM_CH;
  logic [W-1:0] s;
  logic rise, ev, cap, upd, accept, load, hit;
  logic [SW-1:0] act;
  logic [DR_WIDTH-1:0] sr_q, sr_d, wr_data_q, wr_data_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d, cap_sel_q, cap_sel_d, wr_sel_q, wr_sel_d;
  logic shift_prev_q, shift_prev_d, cap_pulse_q, cap_pulse_d;
  logic wr_valid_q, wr_valid_d, wr_ovf_q, wr_ovf_d;
  logic [NUM_CH-1:0] jtdo_q, jtdo_d;

  jtag_sync_edge #(.W(W), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rstn(rstn),
    .tck (jtck),
    .d   ({jce, jrstn, jupdate, jshift, jtdi}),
    .q   (s),
    .rise(rise)
  );

  // lowest-numbered asserted JCE owns the scan
  always_comb begin
    act = '0;
    hit = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (s[B_CE+k]) begin
        act = SW'(k);
        hit = 1'b1;
      end
  end

  // TAP events from the detected TCK rise; a TAP reset aborts the scan and masks the update
  always_comb begin
    ev = rise & s[B_RSTN];
    cap = ev & hit & ~shift_prev_q;
    upd = ev & s[B_UPD];
    accept = wr_valid_q & bus.wr_ready;
    load = upd & (~wr_valid_q | accept);
    sr_d = !s[B_RSTN] ? '0 : cap ? bus.rd_data[act*DR_WIDTH +: DR_WIDTH] :
           (ev & shift_prev_q) ? {s[B_TDI], sr_q[DR_WIDTH-1:1]} : sr_q;
    cur_sel_d = !s[B_RSTN] ? '0 : cap ? act : cur_sel_q;
    shift_prev_d = !s[B_RSTN] ? 1'b0 : rise ? s[B_SHIFT] : shift_prev_q;
    cap_pulse_d = cap;
    cap_sel_d = cap ? act : cap_sel_q;
    wr_valid_d = load | (wr_valid_q & ~accept);
    wr_data_d = load ? sr_q : wr_data_q;
    wr_sel_d = load ? cur_sel_q : wr_sel_q;
    wr_ovf_d = (upd & ~load) | (wr_ovf_q & ~bus.ovf_clr);
    for (int k = 0; k < NUM_CH; k++) jtdo_d[k] = (cur_sel_d == SW'(k)) & sr_d[0];
  end

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
      cur_sel_q <= '0;
      shift_prev_q <= 1'b0;
      cap_pulse_q <= 1'b0;
      cap_sel_q <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q <= '0;
      wr_sel_q <= '0;
      wr_ovf_q <= 1'b0;
      jtdo_q <= '0;
    end else begin
      sr_q <= sr_d;
      cur_sel_q <= cur_sel_d;
      shift_prev_q <= shift_prev_d;
      cap_pulse_q <= cap_pulse_d;
      cap_sel_q <= cap_sel_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q <= wr_data_d;
      wr_sel_q <= wr_sel_d;
      wr_ovf_q <= wr_ovf_d;
      jtdo_q <= jtdo_d;
    end
  end

  assign jtdo = jtdo_q;
  assign bus.cap_pulse = cap_pulse_q;
  assign bus.cap_sel = cap_sel_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_sel = wr_sel_q;
  assign bus.wr_ovf = wr_ovf_q;
endmodule

// File: tb/tb_jtag_dr_bridge.sv
// tb_jtag_dr_bridge: directed scans against a 32-bit/2-channel and an 8-bit/4-channel bridge
module tb_jtag_dr_bridge;
  logic clk = 0, rstn = 0, jtck = 0, jtdi = 0, jshift = 0, jupdate = 0, jrstn = 1;
  logic [3:0] jce = 0;
  logic [1:0] jtdo1;
  logic [3:0] jtdo2;
  int h = 3, n_cmp = 0, n_bad = 0, vcnt = 0, ccnt = 0;
  logic [31:0] lw_data;
  logic lw_sel;
  logic [7:0] lw2_data;
  logic [1:0] lw2_sel;

  jtag_dr_bridge_if #(.DR_WIDTH(32), .NUM_CH(2)) b1 ();
  jtag_dr_bridge_if #(.DR_WIDTH(8), .NUM_CH(4)) b2 ();

  jtag_dr_bridge #(.DR_WIDTH(32), .NUM_CH(2), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rstn(rstn), .jtck(jtck), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
    .jrstn(jrstn), .jce(jce[1:0]), .jtdo(jtdo1), .bus(b1)
  );
  jtag_dr_bridge #(.DR_WIDTH(8), .NUM_CH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rstn(rstn), .jtck(jtck), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
    .jrstn(jrstn), .jce(jce), .jtdo(jtdo2), .bus(b2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b1.wr_valid) begin
      vcnt++;
      lw_data = b1.wr_data;
      lw_sel = b1.wr_sel;
    end
    if (b1.cap_pulse) ccnt++;
    if (b2.wr_valid) begin
      lw2_data = b2.wr_data;
      lw2_sel = b2.wr_sel;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    jtck = 1;
    repeat (h) @(negedge clk);
    jtck = 0;
    repeat (h) @(negedge clk);
  endtask

  task automatic scan(input int ch, input logic [31:0] tdi, input int n, input bit upd,
                      input bit d2, output logic [31:0] tdo);
    tdo = 0;
    jce = 4'(1 << ch);
    jshift = 1;
    tick();
    for (int i = 0; i < n; i++) begin
      tdo[i] = d2 ? jtdo2[ch] : jtdo1[ch];
      jtdi = tdi[i];
      if (i == n - 1) begin
        jshift = 0;
        jce = 0;
      end
      tick();
    end
    if (upd) begin
      jupdate = 1;
      tick();
      jupdate = 0;
    end
  endtask

  task automatic drain();
    b1.wr_ready = 1;
    @(negedge clk);
    b1.wr_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({jtdo1, b1.cap_pulse, b1.cap_sel, b1.wr_valid, b1.wr_ovf, b1.wr_data, b1.wr_sel} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut1: got %h want 0",
               {jtdo1, b1.cap_pulse, b1.cap_sel, b1.wr_valid, b1.wr_ovf, b1.wr_data, b1.wr_sel});
    end
    n_cmp++;
    if ({jtdo2, b2.cap_pulse, b2.cap_sel, b2.wr_valid, b2.wr_ovf, b2.wr_data, b2.wr_sel} !== '0) begin
      n_bad++;
      $display("FAIL reset_dut2: got %h want 0",
               {jtdo2, b2.cap_pulse, b2.cap_sel, b2.wr_valid, b2.wr_ovf, b2.wr_data, b2.wr_sel});
    end
    rstn = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_scan_ch0();
    logic [31:0] tdo;
    int c0 = ccnt;
    scan(0, 32'h1234_5678, 32, 1, 0, tdo);
    n_cmp++;
    if (tdo !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL ch0_tdo: got %h want a5a50f0f", tdo); end
    n_cmp++;
    if (ccnt - c0 !== 1) begin n_bad++; $display("FAIL ch0_cap_count: got %0d want 1", ccnt - c0); end
    n_cmp++;
    if (b1.cap_sel !== 1'b0) begin n_bad++; $display("FAIL ch0_cap_sel: got %h want 0", b1.cap_sel); end
    n_cmp++;
    if (b1.wr_valid !== 1'b1) begin n_bad++; $display("FAIL ch0_wr_valid: got %b want 1", b1.wr_valid); end
    n_cmp++;
    if (b1.wr_data !== 32'h1234_5678) begin n_bad++; $display("FAIL ch0_wr_data: got %h want 12345678", b1.wr_data); end
    n_cmp++;
    if (b1.wr_sel !== 1'b0) begin n_bad++; $display("FAIL ch0_wr_sel: got %h want 0", b1.wr_sel); end
    drain();
  endtask

  task automatic test_ready_ch1();
    logic [31:0] tdo;
    int v0 = vcnt;
    b1.wr_ready = 1;
    scan(1, 32'h0BAD_F00D, 32, 1, 0, tdo);
    b1.wr_ready = 0;
    n_cmp++;
    if (tdo !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ch1_tdo: got %h want deadbeef", tdo); end
    n_cmp++;
    if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL ch1_valid_clks: got %0d want 1", vcnt - v0); end
    n_cmp++;
    if ({lw_sel, lw_data} !== {1'b1, 32'h0BAD_F00D}) begin
      n_bad++;
      $display("FAIL ch1_word: got %b/%h want 1/0badf00d", lw_sel, lw_data);
    end
    n_cmp++;
    if ({b1.cap_sel, b1.wr_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL ch1_sel_valid: got %b/%b want 1/0", b1.cap_sel, b1.wr_valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] tdo;
    scan(0, 32'h1, 32, 1, 0, tdo);
    scan(0, 32'h2, 32, 1, 0, tdo);
    n_cmp++;
    if ({b1.wr_valid, b1.wr_data} !== {1'b1, 32'h1}) begin
      n_bad++;
      $display("FAIL ovf_kept_word: got %b/%h want 1/00000001", b1.wr_valid, b1.wr_data);
    end
    n_cmp++;
    if (b1.wr_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", b1.wr_ovf); end
    b1.ovf_clr = 1;
    @(negedge clk);
    b1.ovf_clr = 0;
    @(negedge clk);
    n_cmp++;
    if (b1.wr_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", b1.wr_ovf); end
    drain();
    n_cmp++;
    if (b1.wr_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain: got %b want 0", b1.wr_valid); end
  endtask

  task automatic test_jtag_reset();
    logic [31:0] tdo;
    int v0 = vcnt;
    scan(0, 32'hFFFF_FFFF, 10, 0, 0, tdo);
    jrstn = 0;
    jupdate = 1;
    tick();
    jupdate = 0;
    jrstn = 1;
    tick();
    n_cmp++;
    if ({vcnt - v0, b1.wr_valid} !== {32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL jrst_no_update: got %0d clks valid=%b want 0/0", vcnt - v0, b1.wr_valid);
    end
    n_cmp++;
    if (jtdo1 !== 2'b00) begin n_bad++; $display("FAIL jrst_tdo_cleared: got %b want 00", jtdo1); end
    scan(0, 32'h1234_5678, 32, 1, 0, tdo);
    n_cmp++;
    if ({tdo, b1.wr_data} !== {32'hA5A5_0F0F, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL jrst_rescan: got %h/%h want a5a50f0f/12345678", tdo, b1.wr_data);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] tdo;
    scan(0, 32'h0, 5, 0, 0, tdo);
    rstn = 0;
    #1;
    n_cmp++;
    if ({jtdo1, b1.cap_pulse, b1.cap_sel, b1.wr_valid, b1.wr_ovf, b1.wr_data, b1.wr_sel} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0",
               {jtdo1, b1.cap_pulse, b1.cap_sel, b1.wr_valid, b1.wr_ovf, b1.wr_data, b1.wr_sel});
    end
    @(negedge clk);
    rstn = 1;
    repeat (4) @(negedge clk);
    scan(1, 32'hCAFE_1234, 32, 1, 0, tdo);
    n_cmp++;
    if ({tdo, b1.wr_data, b1.wr_sel} !== {32'hDEAD_BEEF, 32'hCAFE_1234, 1'b1}) begin
      n_bad++;
      $display("FAIL async_resume: got %h/%h/%b want deadbeef/cafe1234/1", tdo, b1.wr_data, b1.wr_sel);
    end
    drain();
  endtask

  task automatic test_narrow_fast();
    logic [31:0] tdo;
    h = 2;
    scan(3, 32'h0000_00B7, 8, 1, 1, tdo);
    n_cmp++;
    if (tdo[7:0] !== 8'h3C) begin n_bad++; $display("FAIL narrow_tdo: got %h want 3c", tdo[7:0]); end
    n_cmp++;
    if ({lw2_sel, lw2_data} !== {2'd3, 8'hB7}) begin
      n_bad++;
      $display("FAIL narrow_word: got %0d/%h want 3/b7", lw2_sel, lw2_data);
    end
    n_cmp++;
    if (b2.cap_sel !== 2'd3) begin n_bad++; $display("FAIL narrow_cap_sel: got %0d want 3", b2.cap_sel); end
  endtask

  initial begin
    b1.rd_data = {32'hDEAD_BEEF, 32'hA5A5_0F0F};
    b1.wr_ready = 0;
    b1.ovf_clr = 0;
    b2.rd_data = {8'h3C, 8'hC3, 8'h5A, 8'h96};
    b2.wr_ready = 1;
    b2.ovf_clr = 0;
    test_reset();
    test_scan_ch0();
    test_ready_ch1();
    test_overflow();
    test_jtag_reset();
    test_async_reset();
    test_narrow_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
